// File: rtl/decode_pipe.sv
// ID-stage decode and ID/EX + EX/WB pipeline registers: register-select one-hots,
// ALU control capture, immediate sign-extension and destination tracking.
module decode_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ibus,
  input  logic        I,
  input  logic [2:0]  S,
  input  logic        Cin,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] Aselect,
  output logic [31:0] Bselect,
  output logic        ex_I,
  output logic [2:0]  ex_S,
  output logic        ex_Cin,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_Dselect,
  output logic [31:0] wb_Dselect,
  output logic        ex_valid,
  output logic        ex_illegal
);

  localparam logic [2:0] S_UNSUPPORTED = 3'b111;

  logic [4:0]  rs_idx, rt_idx, rd_idx, dest_idx;
  logic [31:0] dest_onehot;
  logic        unused_opcode;

  logic        ex_i_q, ex_i_d;
  logic [2:0]  ex_s_q, ex_s_d;
  logic        ex_cin_q, ex_cin_d;
  logic [31:0] ex_imm_q, ex_imm_d;
  logic [31:0] ex_dsel_q, ex_dsel_d;
  logic        ex_valid_q, ex_valid_d;
  logic        ex_illegal_q, ex_illegal_d;
  logic [31:0] wb_dsel_q, wb_dsel_d;

  assign rs_idx        = ibus[25:21];
  assign rt_idx        = ibus[20:16];
  assign rd_idx        = ibus[15:11];
  assign dest_idx      = I ? rt_idx : rd_idx;
  assign unused_opcode = ^ibus[31:26];

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_onehot
      assign Aselect[gi]     = (rs_idx == 5'(gi));
      assign Bselect[gi]     = (rt_idx == 5'(gi));
      assign dest_onehot[gi] = (dest_idx == 5'(gi));
    end
  endgenerate

  always_comb begin
    ex_i_d       = ex_i_q;
    ex_s_d       = ex_s_q;
    ex_cin_d     = ex_cin_q;
    ex_imm_d     = ex_imm_q;
    ex_dsel_d    = ex_dsel_q;
    ex_valid_d   = ex_valid_q;
    ex_illegal_d = ex_illegal_q;
    // A stalled EX instruction must not retire twice, so WB sees a bubble.
    wb_dsel_d    = stall ? 32'h0 : ex_dsel_q;

    if (flush) begin
      ex_i_d       = 1'b0;
      ex_s_d       = S_UNSUPPORTED;
      ex_cin_d     = 1'b0;
      ex_imm_d     = 32'h0;
      ex_dsel_d    = 32'h0;
      ex_valid_d   = 1'b0;
      ex_illegal_d = 1'b0;
    end else if (!stall) begin
      ex_i_d       = I;
      ex_s_d       = S;
      ex_cin_d     = Cin;
      ex_imm_d     = {{16{ibus[15]}}, ibus[15:0]};
      ex_valid_d   = 1'b1;
      ex_illegal_d = (S == S_UNSUPPORTED);
      ex_dsel_d    = (S == S_UNSUPPORTED) ? 32'h0 : dest_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_i_q       <= 1'b0;
      ex_s_q       <= S_UNSUPPORTED;
      ex_cin_q     <= 1'b0;
      ex_imm_q     <= 32'h0;
      ex_dsel_q    <= 32'h0;
      ex_valid_q   <= 1'b0;
      ex_illegal_q <= 1'b0;
      wb_dsel_q    <= 32'h0;
    end else begin
      ex_i_q       <= ex_i_d;
      ex_s_q       <= ex_s_d;
      ex_cin_q     <= ex_cin_d;
      ex_imm_q     <= ex_imm_d;
      ex_dsel_q    <= ex_dsel_d;
      ex_valid_q   <= ex_valid_d;
      ex_illegal_q <= ex_illegal_d;
      wb_dsel_q    <= wb_dsel_d;
    end
  end

  assign ex_I       = ex_i_q;
  assign ex_S       = ex_s_q;
  assign ex_Cin     = ex_cin_q;
  assign ex_imm     = ex_imm_q;
  assign ex_Dselect = ex_dsel_q;
  assign ex_valid   = ex_valid_q;
  assign ex_illegal = ex_illegal_q;
  assign wb_Dselect = wb_dsel_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed and randomized checks of decode_pipe: decode one-hots, EX capture,
// WB delay, stall/flush/reset priority and the zero-or-one-hot invariant.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        reset, I, Cin, stall, flush;
  logic [31:0] ibus;
  logic [2:0]  S;
  logic [31:0] Aselect, Bselect, ex_imm, ex_Dselect, wb_Dselect;
  logic        ex_I, ex_Cin, ex_valid, ex_illegal;
  logic [2:0]  ex_S;

  int total = 0;
  int bad   = 0;

  // {ex_I, ex_S, ex_Cin, ex_imm, ex_Dselect, ex_valid, ex_illegal}
  logic [70:0] ex_bundle;
  localparam logic [70:0] BUBBLE = {1'b0, 3'b111, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};

  assign ex_bundle = {ex_I, ex_S, ex_Cin, ex_imm, ex_Dselect, ex_valid, ex_illegal};

  decode_pipe dut (
    .clk(clk), .reset(reset), .ibus(ibus), .I(I), .S(S), .Cin(Cin),
    .stall(stall), .flush(flush),
    .Aselect(Aselect), .Bselect(Bselect),
    .ex_I(ex_I), .ex_S(ex_S), .ex_Cin(ex_Cin), .ex_imm(ex_imm),
    .ex_Dselect(ex_Dselect), .wb_Dselect(wb_Dselect),
    .ex_valid(ex_valid), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ib, input logic i_b, input logic [2:0] s_b,
                       input logic c_b);
    ibus = ib; I = i_b; S = s_b; Cin = c_b;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(32'h0C22FFFC, 1'b1, 3'b010, 1'b1);
    tick();
    total++;
    if (ex_bundle !== BUBBLE) begin
      $display("FAIL reset_ex got=%h want=%h", ex_bundle, BUBBLE); bad++;
    end
    total++;
    if (wb_Dselect !== 32'h0) begin
      $display("FAIL reset_wb got=%h want=0", wb_Dselect); bad++;
    end
    $display("xact reset ex_valid=%b wb_Dselect=%h", ex_valid, wb_Dselect);
  endtask

  task automatic test_imm_load();
    reset = 1'b0;
    drive(32'h0C22FFFC, 1'b1, 3'b010, 1'b0);
    #1;
    total++;
    if ({Aselect, Bselect} !== {32'h2, 32'h4}) begin
      $display("FAIL imm_sel got=%h/%h want=2/4", Aselect, Bselect); bad++;
    end
    tick();
    total++;
    if (ex_bundle !== {1'b1, 3'b010, 1'b0, 32'hFFFFFFFC, 32'h4, 1'b1, 1'b0}) begin
      $display("FAIL imm_ex got imm=%h dsel=%h S=%b want imm=FFFFFFFC dsel=4 S=010",
               ex_imm, ex_Dselect, ex_S); bad++;
    end
    $display("xact imm_load ex_imm=%h ex_Dselect=%h", ex_imm, ex_Dselect);
  endtask

  task automatic test_rtype();
    drive(32'h00430803, 1'b0, 3'b010, 1'b0);
    tick();
    total++;
    if (wb_Dselect !== 32'h4) begin
      $display("FAIL imm_wb got=%h want=4", wb_Dselect); bad++;
    end
    total++;
    if (ex_bundle !== {1'b0, 3'b010, 1'b0, 32'h00000803, 32'h2, 1'b1, 1'b0}) begin
      $display("FAIL rtype_ex got I=%b imm=%h dsel=%h want I=0 imm=00000803 dsel=2",
               ex_I, ex_imm, ex_Dselect); bad++;
    end
    $display("xact rtype ex_Dselect=%h wb_Dselect=%h", ex_Dselect, wb_Dselect);
  endtask

  task automatic test_illegal();
    drive(32'hFC000000, 1'b0, 3'b111, 1'b0);
    tick();
    total++;
    if (ex_bundle !== {1'b0, 3'b111, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1}) begin
      $display("FAIL illegal_ex got ill=%b val=%b dsel=%h want 1/1/0",
               ex_illegal, ex_valid, ex_Dselect); bad++;
    end
    drive(32'h0, 1'b0, 3'b000, 1'b0);
    tick();
    total++;
    if (wb_Dselect !== 32'h0) begin
      $display("FAIL illegal_wb got=%h want=0", wb_Dselect); bad++;
    end
    $display("xact illegal ex_illegal=%b wb_Dselect=%h", ex_illegal, wb_Dselect);
  endtask

  task automatic test_r0();
    // I=1 with rt=0 and a negative-free immediate; destination r0 still decodes.
    drive(32'h2000_1234, 1'b1, 3'b001, 1'b1);
    tick();
    total++;
    if (ex_bundle !== {1'b1, 3'b001, 1'b1, 32'h00001234, 32'h1, 1'b1, 1'b0}) begin
      $display("FAIL r0_ex got dsel=%h imm=%h cin=%b want dsel=1 imm=00001234 cin=1",
               ex_Dselect, ex_imm, ex_Cin); bad++;
    end
    $display("xact r0 ex_Dselect=%h", ex_Dselect);
  endtask

  task automatic test_stall_flush();
    logic [70:0] held;
    drive(32'h0C22FFFC, 1'b1, 3'b010, 1'b0);
    tick();
    held = {1'b1, 3'b010, 1'b0, 32'hFFFFFFFC, 32'h4, 1'b1, 1'b0};
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(32'h00430803 + k, 1'b0, 3'(k), 1'b1);
      tick();
      total++;
      if (ex_bundle !== held) begin
        $display("FAIL stall_hold%0d got=%h want=%h", k, ex_bundle, held); bad++;
      end
      total++;
      if (wb_Dselect !== 32'h0) begin
        $display("FAIL stall_wb%0d got=%h want=0", k, wb_Dselect); bad++;
      end
      $display("xact stall%0d ex_Dselect=%h wb_Dselect=%h", k, ex_Dselect, wb_Dselect);
    end
    flush = 1'b1;
    tick();
    total++;
    if (ex_bundle !== BUBBLE) begin
      $display("FAIL flush_ex got S=%b valid=%b want S=111 valid=0", ex_S, ex_valid); bad++;
    end
    stall = 1'b0;
    tick();
    total++;
    if (ex_bundle !== BUBBLE || wb_Dselect !== 32'h0) begin
      $display("FAIL flush_only got ex=%h wb=%h want bubble/0", ex_bundle, wb_Dselect); bad++;
    end
    flush = 1'b0;
    $display("xact flush ex_valid=%b ex_S=%b", ex_valid, ex_S);
  endtask

  task automatic test_reset_mid_stall();
    drive(32'h0C22FFFC, 1'b1, 3'b010, 1'b0);
    tick();
    stall = 1'b1;
    tick();
    total++;
    if (ex_Dselect !== 32'h4) begin
      $display("FAIL pre_reset_hold got=%h want=4", ex_Dselect); bad++;
    end
    reset = 1'b1; flush = 1'b1;
    tick();
    total++;
    if (ex_bundle !== BUBBLE || wb_Dselect !== 32'h0) begin
      $display("FAIL reset_mid_stall got ex=%h wb=%h want bubble/0", ex_bundle, wb_Dselect);
      bad++;
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(32'h00430803, 1'b0, 3'b010, 1'b0);
    tick();
    total++;
    if (ex_bundle !== {1'b0, 3'b010, 1'b0, 32'h00000803, 32'h2, 1'b1, 1'b0}) begin
      $display("FAIL post_reset_capture got=%h", ex_bundle); bad++;
    end
    $display("xact reset_mid_stall ex_Dselect=%h", ex_Dselect);
  endtask

  task automatic test_random();
    logic [70:0] exp_ex, nxt_ex;
    logic [31:0] exp_wb, nxt_wb, sext, dsel;
    logic [4:0]  d;
    int          errs_before;
    errs_before = bad;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    tick();
    reset = 1'b0;
    exp_ex = BUBBLE;
    exp_wb = 32'h0;
    for (int n = 0; n < 1000; n++) begin
      ibus  = $urandom;
      I     = 1'($urandom);
      S     = 3'($urandom);
      Cin   = 1'($urandom);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      d    = I ? ibus[20:16] : ibus[15:11];
      sext = ibus[15] ? {16'hFFFF, ibus[15:0]} : {16'h0000, ibus[15:0]};
      dsel = (S == 3'b111) ? 32'h0 : (32'h1 << d);
      #1;
      total++;
      if (Aselect !== (32'h1 << ibus[25:21]) || Bselect !== (32'h1 << ibus[20:16])) begin
        $display("FAIL rnd_sel%0d got=%h/%h", n, Aselect, Bselect); bad++;
      end
      if (flush)      nxt_ex = BUBBLE;
      else if (stall) nxt_ex = exp_ex;
      else            nxt_ex = {I, S, Cin, sext, dsel, 1'b1, (S == 3'b111)};
      nxt_wb = stall ? 32'h0 : exp_ex[33:2];
      tick();
      exp_ex = nxt_ex;
      exp_wb = nxt_wb;
      total++;
      if (ex_bundle !== exp_ex) begin
        $display("FAIL rnd_ex%0d got=%h want=%h", n, ex_bundle, exp_ex); bad++;
      end
      total++;
      if (wb_Dselect !== exp_wb) begin
        $display("FAIL rnd_wb%0d got=%h want=%h", n, wb_Dselect, exp_wb); bad++;
      end
      total++;
      if ($countones(ex_Dselect) > 1 || $countones(wb_Dselect) > 1) begin
        $display("FAIL rnd_onehot%0d got ex=%h wb=%h", n, ex_Dselect, wb_Dselect); bad++;
      end
      #2;
    end
    stall = 1'b0; flush = 1'b0;
    $display("xact random 1000 cycles new_errors=%0d", bad - errs_before);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    ibus = 32'h0; I = 1'b0; S = 3'b000; Cin = 1'b0;
    #2;
    test_reset();
    test_imm_load();
    test_rtype();
    test_illegal();
    test_r0();
    test_stall_flush();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
